// File: rtl/gf2_row_eliminator_pkg.sv
// Shared definitions for the GF(2) row-elimination sequencer: state encoding,
// address-width derivation and the even/odd port-pair routing rule.
`default_nettype none

package gf2_row_eliminator_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SWEEP = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Even rows are read on port 0 and written back on port 1; odd rows the
  // reverse, so each port pair always sees differing read/write LSBs.
  localparam logic EVEN_LSB = 1'b0;
  localparam logic ODD_LSB  = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf2_row_eliminator_update.sv
// One writeback lane: decides whether a streamed row takes the pivot XOR.
`default_nettype none

module gf2_row_update #(
  parameter int WIDTH = 8,
  parameter int AW    = 6,
  parameter int CW    = 3
) (
  input  logic             valid,
  input  logic [WIDTH-1:0] row,
  input  logic [WIDTH-1:0] piv,
  input  logic [CW-1:0]    col,
  input  logic [AW-1:0]    addr,
  input  logic [AW-1:0]    pivot_addr,
  output logic             wren,
  output logic [WIDTH-1:0] data
);

  assign wren = valid && row[col] && (addr != pivot_addr);
  assign data = wren ? (row ^ piv) : '0;

endmodule

`default_nettype wire

// File: rtl/gf2_row_eliminator.sv
// One GF(2) elimination step: streams all row pairs through mem_quad and XORs
// the pivot row into every other row having a 1 in the pivot column.
`default_nettype none

module gf2_row_eliminator
  import gf2_row_eliminator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW   = clog2_min1(DEPTH),
  localparam int CW   = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    pivot_addr,
  input  logic [CW-1:0]    col,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    rdaddress0,
  output logic [AW-1:0]    rdaddress1,
  output logic             rden0,
  output logic             rden1,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  output logic [AW-1:0]    wraddress0,
  output logic [AW-1:0]    wraddress1,
  output logic             wren0,
  output logic             wren1,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1
);

  state_t            state, next_state;
  logic [AW-1:0]     pivot_r;
  logic [CW-1:0]     col_r;
  logic [WIDTH-1:0]  piv_r;
  logic              err_r;
  logic [AW-2:0]     k_r;
  logic [AW-2:0]     kp_r;
  logic              inflight_r;

  logic [WIDTH-1:0]  pivot_word;
  logic [AW-1:0]     even_wr_addr;
  logic [AW-1:0]     odd_wr_addr;
  logic              even_wren;
  logic              odd_wren;
  logic [WIDTH-1:0]  even_data;
  logic [WIDTH-1:0]  odd_data;

  assign pivot_word = pivot_r[0] ? q1 : q0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pivot_r    <= '0;
      col_r      <= '0;
      piv_r      <= '0;
      err_r      <= 1'b0;
      k_r        <= '0;
      kp_r       <= '0;
      inflight_r <= 1'b0;
    end else begin
      state      <= next_state;
      inflight_r <= (state == S_SWEEP);
      kp_r       <= k_r;
      case (state)
        S_IDLE: begin
          if (start) begin
            pivot_r <= pivot_addr;
            col_r   <= col;
            err_r   <= 1'b0;
          end
        end
        S_CHECK: begin
          piv_r <= pivot_word;
          err_r <= !pivot_word[col_r];
          k_r   <= '0;
        end
        S_SWEEP: k_r <= k_r + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_CHECK;
      S_CHECK: next_state = pivot_word[col_r] ? S_SWEEP : S_FIN;
      S_SWEEP: if (k_r == '1) next_state = S_DRAIN;
      S_DRAIN: next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rden0      = 1'b0;
    rden1      = 1'b0;
    rdaddress0 = '0;
    rdaddress1 = '0;
    case (state)
      S_LOAD: begin
        if (pivot_r[0]) begin
          rden1      = 1'b1;
          rdaddress1 = pivot_r;
        end else begin
          rden0      = 1'b1;
          rdaddress0 = pivot_r;
        end
      end
      S_SWEEP: begin
        rden0      = 1'b1;
        rden1      = 1'b1;
        rdaddress0 = {k_r, EVEN_LSB};
        rdaddress1 = {k_r, ODD_LSB};
      end
      default: ;
    endcase
  end

  assign busy = (state == S_LOAD) || (state == S_CHECK) ||
                (state == S_SWEEP) || (state == S_DRAIN);
  assign done = (state == S_FIN);
  assign err  = (state == S_FIN) && err_r;

  assign even_wr_addr = {kp_r, EVEN_LSB};
  assign odd_wr_addr  = {kp_r, ODD_LSB};

  gf2_row_update #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) u_even_lane (
    .valid      (inflight_r),
    .row        (q0),
    .piv        (piv_r),
    .col        (col_r),
    .addr       (even_wr_addr),
    .pivot_addr (pivot_r),
    .wren       (even_wren),
    .data       (even_data)
  );

  gf2_row_update #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) u_odd_lane (
    .valid      (inflight_r),
    .row        (q1),
    .piv        (piv_r),
    .col        (col_r),
    .addr       (odd_wr_addr),
    .pivot_addr (pivot_r),
    .wren       (odd_wren),
    .data       (odd_data)
  );

  assign wren1      = even_wren;
  assign data1      = even_data;
  assign wraddress1 = even_wren ? even_wr_addr : '0;
  assign wren0      = odd_wren;
  assign data0      = odd_data;
  assign wraddress0 = odd_wren ? odd_wr_addr : '0;

endmodule

`default_nettype wire

// File: tb/tb_gf2_row_eliminator.sv
// Randomized and directed checks of gf2_row_eliminator against a software GF(2) model.
`default_nettype none

module tb_gf2_row_eliminator;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 3;
  localparam int LAT   = 4 + DEPTH / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    pivot_addr = '0;
  logic [CW-1:0]    col = '0;
  logic             busy, done, err;
  logic [AW-1:0]    rdaddress0, rdaddress1, wraddress0, wraddress1;
  logic             rden0, rden1, wren0, wren1;
  logic [WIDTH-1:0] q0 = '0;
  logic [WIDTH-1:0] q1 = '0;
  logic [WIDTH-1:0] data0, data1;

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] model [DEPTH];
  int               write_count = 0;
  int               vectors = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  gf2_row_eliminator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pivot_addr (pivot_addr),
    .col        (col),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdaddress0 (rdaddress0),
    .rdaddress1 (rdaddress1),
    .rden0      (rden0),
    .rden1      (rden1),
    .q0         (q0),
    .q1         (q1),
    .wraddress0 (wraddress0),
    .wraddress1 (wraddress1),
    .wren0      (wren0),
    .wren1      (wren1),
    .data0      (data0),
    .data1      (data1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory with one-cycle read latency; writes land at the clock edge.
  always @(posedge clk) begin
    if (rden0) q0 <= mem[rdaddress0];
    if (rden1) q1 <= mem[rdaddress1];
    if (wren0) begin mem[wraddress0] = data0; write_count++; end
    if (wren1) begin mem[wraddress1] = data1; write_count++; end
  end

  always @(negedge clk) begin
    if (rden0 && wren0) check("lsb_port0", {63'd0, rdaddress0[0] != wraddress0[0]}, 64'd1);
    if (rden1 && wren1) check("lsb_port1", {63'd0, rdaddress1[0] != wraddress1[0]}, 64'd1);
  end

  task automatic load_rows(input logic [63:0] v);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = v[8*i +: 8];
      model[i] = v[8*i +: 8];
    end
  endtask

  // Reference: XOR the pivot row into every other row with a 1 at col.
  task automatic model_step(input int p, input int c, output bit e);
    logic [WIDTH-1:0] pv;
    pv = model[p];
    e  = (pv[c] == 1'b0);
    if (!e)
      for (int r = 0; r < DEPTH; r++)
        if (r != p && model[r][c]) model[r] = model[r] ^ pv;
  endtask

  function automatic int model_writes(input int p, input int c);
    int n;
    n = 0;
    if (model[p][c])
      for (int r = 0; r < DEPTH; r++)
        if (r != p && model[r][c]) n++;
    return n;
  endfunction

  task automatic compare_mem(input string tag);
    logic [63:0] got, exp;
    for (int i = 0; i < DEPTH; i++) begin
      got[8*i +: 8] = mem[i];
      exp[8*i +: 8] = model[i];
    end
    check(tag, got, exp);
  endtask

  task automatic run_cmd(input int p, input int c, input bit pulse_again,
                         output int lat, output bit e);
    start = 1'b1; pivot_addr = AW'(p); col = CW'(c);
    lat = 0; e = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      start = pulse_again && (lat == 4);
      if (pulse_again && lat == 4) pivot_addr = 3'd6;
      if (lat == 2) check("busy_mid", {63'd0, busy}, 64'd1);
      if (done) begin
        e = err;
        check("busy_at_done", {63'd0, busy}, 64'd0);
        break;
      end
      if (lat > 200) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic full_cmd(input string tag, input int p, input int c, input bit pulse_again);
    int lat; bit e; bit exp_e; int exp_w;
    exp_w = model_writes(p, c);
    write_count = 0;
    run_cmd(p, c, pulse_again, lat, e);
    model_step(p, c, exp_e);
    check({tag, "_err"}, {63'd0, e}, {63'd0, exp_e});
    check({tag, "_lat"}, 64'(lat), exp_e ? 64'd3 : 64'(LAT));
    check({tag, "_writes"}, 64'(write_count), 64'(exp_w));
    compare_mem({tag, "_mem"});
  endtask

  function automatic logic [63:0] outs_vec();
    return {29'd0, busy, done, err, rden0, rden1, wren0, wren1,
            rdaddress0, rdaddress1, wraddress0, wraddress1, data0, data1};
  endfunction

  localparam logic [63:0] BASE = 64'h4100_FF80_0302_0181;

  initial begin
    int lat; bit e; int extra_done;
    logic [63:0] rnd;
    int p, c;

    #2;
    check("reset_outputs", outs_vec(), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    load_rows(BASE);
    @(negedge clk);

    // Pivot 1, col 0 with explicit expected matrix.
    write_count = 0;
    run_cmd(1, 0, 1'b0, lat, e);
    check("s1_err", {63'd0, e}, 64'd0);
    check("s1_lat", 64'(lat), 64'd8);
    check("s1_writes", 64'(write_count), 64'd4);
    for (int i = 0; i < DEPTH; i++) model[i] = mem[i];
    compare_mem("s1_self");
    begin
      logic [63:0] got;
      for (int i = 0; i < DEPTH; i++) got[8*i +: 8] = mem[i];
      check("s1_matrix", got, 64'h4000_FE80_0202_0180);
    end

    // Pivot bit is 0: error path, no writes.
    load_rows(BASE);
    @(negedge clk);
    full_cmd("s2", 2, 0, 1'b0);

    // Even pivot, top column.
    load_rows(BASE);
    @(negedge clk);
    full_cmd("s3", 4, 7, 1'b0);

    // Second start during SWEEP must be ignored.
    load_rows(BASE);
    @(negedge clk);
    full_cmd("s4", 1, 0, 1'b1);
    extra_done = 0;
    repeat (10) begin @(negedge clk); if (done) extra_done++; end
    check("s4_single_done", 64'(extra_done), 64'd0);

    // Asynchronous reset during SWEEP k=2.
    load_rows(BASE);
    @(negedge clk);
    start = 1'b1; pivot_addr = 3'd1; col = 3'd0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", outs_vec(), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    load_rows(BASE);
    @(negedge clk);
    full_cmd("s5", 1, 0, 1'b0);

    // Back-to-back commands.
    load_rows(BASE);
    @(negedge clk);
    full_cmd("s6a", 1, 0, 1'b0);
    @(negedge clk);
    full_cmd("s6b", 5, 1, 1'b0);

    // Randomized matrices and pivots.
    for (int t = 0; t < 10; t++) begin
      rnd = {$urandom, $urandom};
      p = int'($urandom_range(0, DEPTH - 1));
      c = int'($urandom_range(0, WIDTH - 1));
      if (t % 3 != 0) rnd[8*p + c] = 1'b1;
      load_rows(rnd);
      @(negedge clk);
      full_cmd("rand", p, c, 1'b0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
